forward_source_pipe: RTL and testbench

Producer side of the operand-forwarding network. Carries each issued instruction's destination register and result from EX through the D$ pipeline stages into MM and WB. Drives the per-stage `waddr`/`wdata` buses consumed by the decode-stage forwarding mux. Because load data is not yet available while a load sits in the D$ stages, the block also evaluates decode's source registers against in-flight loads and raises a load-use hazard.

---
 rtl/cpu_defs.sv | 44 ++++
 rtl/forward_source_pipe_if.sv | 47 ++++
 rtl/fwd_hazard_check.sv | 33 +++
 rtl/forward_source_pipe.sv | 163 ++++++++++++++++
 tb/tb_forward_source_pipe.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the operand-forwarding network.
//   reg_addr_t  : architectural register index (r0 is hard-wired zero)
//   uint32_t    : 32-bit data word
//   fwd_entry_t : one forwarding-pipeline slot (valid, ready, waddr, wdata)
// Helpers build an EX-stage entry and derive what a slot drives onto a
// forwarding bus.
package cpu_defs;

  localparam int DEFAULT_ISSUE_NUM         = 2;
  localparam int DEFAULT_DCACHE_PIPE_DEPTH = 3;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    logic      valid;
    logic      ready;
    reg_addr_t waddr;
    uint32_t   wdata;
  } fwd_entry_t;

  // Loads have no data yet: they enter not-ready with a zero payload.
  function automatic fwd_entry_t make_ex_entry(input logic      valid,
                                               input logic      is_load,
                                               input reg_addr_t waddr,
                                               input uint32_t   wdata);
    fwd_entry_t e;
    e.valid = valid;
    e.ready = !is_load;
    e.waddr = waddr;
    e.wdata = is_load ? '0 : wdata;
    return e;
  endfunction

  // A pending load must never look like a forwardable producer.
  function automatic reg_addr_t bus_waddr(input fwd_entry_t e);
    return (e.valid && e.ready) ? e.waddr : '0;
  endfunction

  function automatic uint32_t bus_wdata(input fwd_entry_t e);
    return e.valid ? e.wdata : '0;
  endfunction

endpackage

// File: rtl/forward_source_pipe_if.sv
// Bus bundle of forward_source_pipe.
//   master : EX/decode side, drives stall/flush, EX lanes, load data, rs1/rs2
//            and observes the per-stage forwarding buses and hazard.
//   slave  : the forwarding pipe itself.
// dcache_* buses are indexed [stage][lane]; stage 0 is the youngest D$ stage.
interface forward_source_pipe_if
  import cpu_defs::*;
#(
  parameter int ISSUE_NUM         = DEFAULT_ISSUE_NUM,
  parameter int DCACHE_PIPE_DEPTH = DEFAULT_DCACHE_PIPE_DEPTH
) ();

  logic                                          stall_i;
  logic                                          flush_i;
  logic      [ISSUE_NUM-1:0]                     ex_valid_i;
  logic      [ISSUE_NUM-1:0]                     ex_is_load_i;
  reg_addr_t [ISSUE_NUM-1:0]                     ex_waddr_i;
  uint32_t   [ISSUE_NUM-1:0]                     ex_wdata_i;
  uint32_t   [ISSUE_NUM-1:0]                     load_rdata_i;
  reg_addr_t                                     rs1_i;
  reg_addr_t                                     rs2_i;

  reg_addr_t [ISSUE_NUM-1:0]                     ex_waddr_o;
  uint32_t   [ISSUE_NUM-1:0]                     ex_wdata_o;
  reg_addr_t [DCACHE_PIPE_DEPTH-2:0][ISSUE_NUM-1:0] dcache_waddr_o;
  uint32_t   [DCACHE_PIPE_DEPTH-2:0][ISSUE_NUM-1:0] dcache_wdata_o;
  reg_addr_t [ISSUE_NUM-1:0]                     mm_waddr_o;
  uint32_t   [ISSUE_NUM-1:0]                     mm_wdata_o;
  reg_addr_t [ISSUE_NUM-1:0]                     wb_waddr_o;
  uint32_t   [ISSUE_NUM-1:0]                     wb_wdata_o;
  logic                                          hazard_o;

  modport master (
    output stall_i, flush_i, ex_valid_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
           load_rdata_i, rs1_i, rs2_i,
    input  ex_waddr_o, ex_wdata_o, dcache_waddr_o, dcache_wdata_o,
           mm_waddr_o, mm_wdata_o, wb_waddr_o, wb_wdata_o, hazard_o
  );

  modport slave (
    input  stall_i, flush_i, ex_valid_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
           load_rdata_i, rs1_i, rs2_i,
    output ex_waddr_o, ex_wdata_o, dcache_waddr_o, dcache_wdata_o,
           mm_waddr_o, mm_wdata_o, wb_waddr_o, wb_wdata_o, hazard_o
  );

endinterface

// File: rtl/fwd_hazard_check.sv
// Load-use hazard check for one decode source register.
//   rs         : source register being resolved (r0 never hazards)
//   src_valid  : per-source valid, index 0 = highest priority (youngest)
//   src_ready  : per-source ready (0 = load still waiting for data)
//   src_waddr  : per-source destination register
//   hazard     : the highest-priority matching source is a pending load
module fwd_hazard_check
  import cpu_defs::*;
#(
  parameter int NUM_SRC = 8
) (
  input  reg_addr_t                 rs,
  input  logic      [NUM_SRC-1:0]   src_valid,
  input  logic      [NUM_SRC-1:0]   src_ready,
  input  reg_addr_t [NUM_SRC-1:0]   src_waddr,
  output logic                      hazard
);

  logic pending;

  // Walk from oldest to youngest so the youngest match is the last write;
  // a ready younger producer therefore shadows an older pending load.
  always_comb begin
    pending = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i] && (src_waddr[i] == rs)) begin
        pending = !src_ready[i];
      end
    end
    hazard = (rs != '0) && pending;
  end

endmodule

// File: rtl/forward_source_pipe.sv
// Producer side of the operand-forwarding network. Carries each issued
// destination register/result from EX through the D$ stages into MM and WB,
// drives the per-stage forwarding buses and flags load-use hazards for
// decode.
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   bus             : forward_source_pipe_if.slave (EX inputs, load data,
//                     rs1/rs2, stall/flush, forwarding buses, hazard)
//   hazard_cycles_o : saturating count of hazard cycles, present only when
//                     FORWARD_HAZARD_STAT_EN is defined
module forward_source_pipe
  import cpu_defs::*;
#(
  parameter int ISSUE_NUM         = DEFAULT_ISSUE_NUM,
  parameter int DCACHE_PIPE_DEPTH = DEFAULT_DCACHE_PIPE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  forward_source_pipe_if.slave  bus
`ifdef FORWARD_HAZARD_STAT_EN
  ,
  output logic [31:0]           hazard_cycles_o
`endif
);

  localparam int DC_STAGES = DCACHE_PIPE_DEPTH - 1;
  // Sources in priority order: EX, D$[0..DC_STAGES-1], MM, WB.
  localparam int NUM_SRC   = (DCACHE_PIPE_DEPTH + 2) * ISSUE_NUM;

  fwd_entry_t [ISSUE_NUM-1:0]                ex_e;
  fwd_entry_t [DC_STAGES-1:0][ISSUE_NUM-1:0] dc_q;
  fwd_entry_t [ISSUE_NUM-1:0]                mm_q;
  fwd_entry_t [ISSUE_NUM-1:0]                mm_d;
  fwd_entry_t [ISSUE_NUM-1:0]                wb_q;

  logic      [NUM_SRC-1:0] src_valid;
  logic      [NUM_SRC-1:0] src_ready;
  reg_addr_t [NUM_SRC-1:0] src_waddr;
  logic                    hazard_rs1;
  logic                    hazard_rs2;
  logic                    hazard;

  // A flushed EX slot is treated as empty both for forwarding and hazards.
  always_comb begin
    ex_e = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      ex_e[j] = make_ex_entry(bus.ex_valid_i[j] && !bus.flush_i,
                              bus.ex_is_load_i[j],
                              bus.ex_waddr_i[j],
                              bus.ex_wdata_i[j]);
    end
  end

  // Load data arrives as an entry leaves the last D$ stage.
  always_comb begin
    mm_d = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      mm_d[j] = dc_q[DC_STAGES-1][j];
      if (mm_d[j].valid && !mm_d[j].ready) begin
        mm_d[j].wdata = bus.load_rdata_i[j];
        mm_d[j].ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_q <= '0;
      mm_q <= '0;
      wb_q <= '0;
    end else if (bus.flush_i) begin
      dc_q <= '0;
      if (!bus.stall_i) begin
        mm_q <= '0;
        wb_q <= mm_q;
      end
    end else if (!bus.stall_i) begin
      dc_q[0] <= ex_e;
      for (int k = 1; k < DC_STAGES; k++) begin
        dc_q[k] <= dc_q[k-1];
      end
      mm_q <= mm_d;
      wb_q <= mm_q;
    end
  end

  always_comb begin
    bus.ex_waddr_o     = '0;
    bus.ex_wdata_o     = '0;
    bus.dcache_waddr_o = '0;
    bus.dcache_wdata_o = '0;
    bus.mm_waddr_o     = '0;
    bus.mm_wdata_o     = '0;
    bus.wb_waddr_o     = '0;
    bus.wb_wdata_o     = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      bus.ex_waddr_o[j] = bus_waddr(ex_e[j]);
      bus.ex_wdata_o[j] = bus_wdata(ex_e[j]);
      for (int k = 0; k < DC_STAGES; k++) begin
        bus.dcache_waddr_o[k][j] = bus_waddr(dc_q[k][j]);
        bus.dcache_wdata_o[k][j] = bus_wdata(dc_q[k][j]);
      end
      bus.mm_waddr_o[j] = bus_waddr(mm_q[j]);
      bus.mm_wdata_o[j] = bus_wdata(mm_q[j]);
      bus.wb_waddr_o[j] = bus_waddr(wb_q[j]);
      bus.wb_wdata_o[j] = bus_wdata(wb_q[j]);
    end
  end

  // Flatten stages youngest first; within a stage the higher lane is placed
  // first so it wins the priority scan.
  always_comb begin
    src_valid = '0;
    src_ready = '0;
    src_waddr = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      src_valid[ISSUE_NUM-1-j] = ex_e[j].valid;
      src_ready[ISSUE_NUM-1-j] = ex_e[j].ready;
      src_waddr[ISSUE_NUM-1-j] = ex_e[j].waddr;
      for (int k = 0; k < DC_STAGES; k++) begin
        src_valid[(k+1)*ISSUE_NUM + ISSUE_NUM-1-j] = dc_q[k][j].valid;
        src_ready[(k+1)*ISSUE_NUM + ISSUE_NUM-1-j] = dc_q[k][j].ready;
        src_waddr[(k+1)*ISSUE_NUM + ISSUE_NUM-1-j] = dc_q[k][j].waddr;
      end
      src_valid[DCACHE_PIPE_DEPTH*ISSUE_NUM + ISSUE_NUM-1-j]     = mm_q[j].valid;
      src_ready[DCACHE_PIPE_DEPTH*ISSUE_NUM + ISSUE_NUM-1-j]     = mm_q[j].ready;
      src_waddr[DCACHE_PIPE_DEPTH*ISSUE_NUM + ISSUE_NUM-1-j]     = mm_q[j].waddr;
      src_valid[(DCACHE_PIPE_DEPTH+1)*ISSUE_NUM + ISSUE_NUM-1-j] = wb_q[j].valid;
      src_ready[(DCACHE_PIPE_DEPTH+1)*ISSUE_NUM + ISSUE_NUM-1-j] = wb_q[j].ready;
      src_waddr[(DCACHE_PIPE_DEPTH+1)*ISSUE_NUM + ISSUE_NUM-1-j] = wb_q[j].waddr;
    end
  end

  fwd_hazard_check #(.NUM_SRC(NUM_SRC)) u_hazard_rs1 (
    .rs        (bus.rs1_i),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_waddr (src_waddr),
    .hazard    (hazard_rs1)
  );

  fwd_hazard_check #(.NUM_SRC(NUM_SRC)) u_hazard_rs2 (
    .rs        (bus.rs2_i),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_waddr (src_waddr),
    .hazard    (hazard_rs2)
  );

  assign hazard       = hazard_rs1 | hazard_rs2;
  assign bus.hazard_o = hazard;

`ifdef FORWARD_HAZARD_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cycles_o <= '0;
    end else if (hazard && (hazard_cycles_o != 32'hFFFF_FFFF)) begin
      hazard_cycles_o <= hazard_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_source_pipe.sv
module tb_forward_source_pipe;
  import cpu_defs::*;

  localparam int IN = 2;
  localparam int DP = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  forward_source_pipe_if #(.ISSUE_NUM(IN), .DCACHE_PIPE_DEPTH(DP)) bus ();

`ifdef FORWARD_HAZARD_STAT_EN
  logic [31:0] hazard_cycles;
`endif

  forward_source_pipe #(.ISSUE_NUM(IN), .DCACHE_PIPE_DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FORWARD_HAZARD_STAT_EN
    ,
    .hazard_cycles_o (hazard_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] lane;
    reg_addr_t  waddr;
    uint32_t    wdata;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  bit      mon_adv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_ex();
    bus.ex_valid_i   = '0;
    bus.ex_is_load_i = '0;
    bus.ex_waddr_i   = '0;
    bus.ex_wdata_i   = '0;
  endtask

  task automatic issue(input int lane, input bit ld, input reg_addr_t a, input uint32_t d);
    bus.ex_valid_i[lane]   = 1'b1;
    bus.ex_is_load_i[lane] = ld;
    bus.ex_waddr_i[lane]   = a;
    bus.ex_wdata_i[lane]   = d;
  endtask

  task automatic expect_wb(input int lane, input reg_addr_t a, input uint32_t d);
    sb_q.push_back(wb_exp_t'{lane: 8'(lane), waddr: a, wdata: d});
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < IN; j++) begin
      chk($sformatf("%s_ex_waddr%0d", tag, j), bus.ex_waddr_o[j], 0);
      chk($sformatf("%s_ex_wdata%0d", tag, j), bus.ex_wdata_o[j], 0);
      for (int k = 0; k < DP - 1; k++) begin
        chk($sformatf("%s_dc%0d_waddr%0d", tag, k, j), bus.dcache_waddr_o[k][j], 0);
        chk($sformatf("%s_dc%0d_wdata%0d", tag, k, j), bus.dcache_wdata_o[k][j], 0);
      end
      chk($sformatf("%s_mm_waddr%0d", tag, j), bus.mm_waddr_o[j], 0);
      chk($sformatf("%s_mm_wdata%0d", tag, j), bus.mm_wdata_o[j], 0);
      chk($sformatf("%s_wb_waddr%0d", tag, j), bus.wb_waddr_o[j], 0);
      chk($sformatf("%s_wb_wdata%0d", tag, j), bus.wb_wdata_o[j], 0);
    end
    chk({tag, "_hazard"}, bus.hazard_o, 0);
`ifdef FORWARD_HAZARD_STAT_EN
    chk({tag, "_hazard_cycles"}, hazard_cycles, 0);
`endif
  endtask

  // Scoreboard monitor: every register write presented on the WB port after
  // an advancing edge is matched against the next expected write.
  always @(posedge clk) begin
    mon_adv = (rst_n === 1'b1) && (bus.stall_i === 1'b0);
    #2;
    if (mon_adv && rst_n) begin
      for (int j = 0; j < IN; j++) begin
        if (bus.wb_waddr_o[j] != '0) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected lane=%0d actual waddr=%0d wdata=0x%0h required=none",
                     j, bus.wb_waddr_o[j], bus.wb_wdata_o[j]);
          end else begin
            wb_exp_t e;
            e = sb_q.pop_front();
            if (e.lane != 8'(j) || e.waddr != bus.wb_waddr_o[j] || e.wdata != bus.wb_wdata_o[j]) begin
              errors++;
              $display("FAIL wb_write actual lane=%0d waddr=%0d wdata=0x%0h required lane=%0d waddr=%0d wdata=0x%0h",
                       j, bus.wb_waddr_o[j], bus.wb_wdata_o[j], e.lane, e.waddr, e.wdata);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_ex();
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.load_rdata_i = '0;
    bus.rs1_i        = '0;
    bus.rs2_i        = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Single ALU write r5 = 0x1234 on lane 0.
    next(); issue(0, 1'b0, 5'd5, 32'h1234); expect_wb(0, 5'd5, 32'h1234); #1;
    chk("t1_ex_waddr", bus.ex_waddr_o[0], 5);
    chk("t1_ex_wdata", bus.ex_wdata_o[0], 32'h1234);
    chk("t1_hz_ex", bus.hazard_o, 0);
    next(); idle_ex(); #1;
    chk("t1_dc0_waddr", bus.dcache_waddr_o[0][0], 5);
    chk("t1_dc0_wdata", bus.dcache_wdata_o[0][0], 32'h1234);
    chk("t1_ex_clear", bus.ex_waddr_o[0], 0);
    chk("t1_hz_dc0", bus.hazard_o, 0);
    next(); #1;
    chk("t1_dc1_waddr", bus.dcache_waddr_o[1][0], 5);
    chk("t1_dc0_empty", bus.dcache_waddr_o[0][0], 0);
    next(); #1;
    chk("t1_mm_waddr", bus.mm_waddr_o[0], 5);
    chk("t1_mm_wdata", bus.mm_wdata_o[0], 32'h1234);
    next(); #1;
    chk("t1_wb_waddr", bus.wb_waddr_o[0], 5);
    chk("t1_wb_wdata", bus.wb_wdata_o[0], 32'h1234);
    chk("t1_mm_empty", bus.mm_waddr_o[0], 0);
    chk("t1_hz_wb", bus.hazard_o, 0);
    repeat (2) next();

    // Load r7 on lane 1, decode wants rs1 = r7.
    next(); bus.rs1_i = 5'd7; issue(1, 1'b1, 5'd7, 32'hFFFF_FFFF);
    expect_wb(1, 5'd7, 32'hDEAD_BEEF); #1;
    chk("t2_hz_ex", bus.hazard_o, 1);
    chk("t2_ex_waddr", bus.ex_waddr_o[1], 0);
    chk("t2_ex_wdata", bus.ex_wdata_o[1], 0);
    next(); idle_ex(); #1;
    chk("t2_hz_dc0", bus.hazard_o, 1);
    chk("t2_dc0_waddr", bus.dcache_waddr_o[0][1], 0);
    next(); bus.load_rdata_i[1] = 32'hDEAD_BEEF; #1;
    chk("t2_hz_dc1", bus.hazard_o, 1);
    chk("t2_dc1_waddr", bus.dcache_waddr_o[1][1], 0);
    next(); bus.load_rdata_i = '0; #1;
    chk("t2_mm_waddr", bus.mm_waddr_o[1], 7);
    chk("t2_mm_wdata", bus.mm_wdata_o[1], 32'hDEAD_BEEF);
    chk("t2_hz_mm", bus.hazard_o, 0);
    next(); bus.rs1_i = '0;
    repeat (2) next();

    // Younger ready ALU r3 shadows an older pending load of r3.
    next(); bus.rs2_i = 5'd3; issue(0, 1'b1, 5'd3, 32'h0);
    expect_wb(0, 5'd3, 32'hA5A5_0003); #1;
    chk("t3_hz_load_ex", bus.hazard_o, 1);
    next(); idle_ex(); issue(0, 1'b0, 5'd3, 32'h55); expect_wb(0, 5'd3, 32'h55); #1;
    chk("t3_hz_shadow_ex", bus.hazard_o, 0);
    next(); idle_ex(); bus.load_rdata_i[0] = 32'hA5A5_0003; #1;
    chk("t3_hz_shadow_dc", bus.hazard_o, 0);
    chk("t3_dc0_waddr", bus.dcache_waddr_o[0][0], 3);
    chk("t3_dc0_wdata", bus.dcache_wdata_o[0][0], 32'h55);
    chk("t3_dc1_waddr", bus.dcache_waddr_o[1][0], 0);
    next(); bus.load_rdata_i = '0; #1;
    chk("t3_mm_waddr", bus.mm_waddr_o[0], 3);
    chk("t3_mm_wdata", bus.mm_wdata_o[0], 32'hA5A5_0003);
    chk("t3_hz_mm", bus.hazard_o, 0);
    bus.rs2_i = '0;
    repeat (4) next();

    // Stall three edges with a load r9 (lane 0) and ALU r10 (lane 1) in D$[0].
    next(); bus.rs1_i = 5'd9; issue(0, 1'b1, 5'd9, 32'h0); issue(1, 1'b0, 5'd10, 32'h77);
    expect_wb(0, 5'd9, 32'h9999); expect_wb(1, 5'd10, 32'h77); #1;
    chk("t4_hz_ex", bus.hazard_o, 1);
    chk("t4_ex_waddr1", bus.ex_waddr_o[1], 10);
    for (int i = 0; i < 4; i++) begin
      next();
      if (i == 0) begin idle_ex(); bus.stall_i = 1'b1; end
      if (i == 3) bus.stall_i = 1'b0;
      #1;
      chk($sformatf("t4_hold%0d_dc0_waddr1", i), bus.dcache_waddr_o[0][1], 10);
      chk($sformatf("t4_hold%0d_dc0_wdata1", i), bus.dcache_wdata_o[0][1], 32'h77);
      chk($sformatf("t4_hold%0d_dc0_waddr0", i), bus.dcache_waddr_o[0][0], 0);
      chk($sformatf("t4_hold%0d_dc1_waddr1", i), bus.dcache_waddr_o[1][1], 0);
      chk($sformatf("t4_hold%0d_mm_waddr0", i), bus.mm_waddr_o[0], 0);
      chk($sformatf("t4_hold%0d_hz", i), bus.hazard_o, 1);
    end
    next(); bus.load_rdata_i[0] = 32'h9999; #1;
    chk("t4_dc1_waddr1", bus.dcache_waddr_o[1][1], 10);
    chk("t4_dc0_waddr1", bus.dcache_waddr_o[0][1], 0);
    chk("t4_hz_dc1", bus.hazard_o, 1);
    next(); bus.load_rdata_i = '0; #1;
    chk("t4_mm_waddr0", bus.mm_waddr_o[0], 9);
    chk("t4_mm_wdata0", bus.mm_wdata_o[0], 32'h9999);
    chk("t4_mm_waddr1", bus.mm_waddr_o[1], 10);
    chk("t4_hz_mm", bus.hazard_o, 0);
    bus.rs1_i = '0;
    repeat (4) next();

    // Flush with every stage occupied: r11 (WB) r12 (MM) r13 r14 (D$) r15 (EX).
    for (int k = 0; k < 5; k++) begin
      next(); idle_ex(); issue(0, 1'b0, reg_addr_t'(11 + k), 32'(32'h1100 + k));
      if (k < 2) expect_wb(0, reg_addr_t'(11 + k), 32'(32'h1100 + k));
      if (k == 4) bus.flush_i = 1'b1;
      #1;
      if (k == 4) begin
        chk("t5_ex_flushed", bus.ex_waddr_o[0], 0);
        chk("t5_pre_wb", bus.wb_waddr_o[0], 11);
        chk("t5_pre_mm", bus.mm_waddr_o[0], 12);
        chk("t5_pre_dc1", bus.dcache_waddr_o[1][0], 13);
        chk("t5_pre_dc0", bus.dcache_waddr_o[0][0], 14);
      end
    end
    next(); idle_ex(); bus.flush_i = 1'b0; #1;
    chk("t5_dc0", bus.dcache_waddr_o[0][0], 0);
    chk("t5_dc1", bus.dcache_waddr_o[1][0], 0);
    chk("t5_mm_bubble", bus.mm_waddr_o[0], 0);
    chk("t5_wb_waddr", bus.wb_waddr_o[0], 12);
    chk("t5_wb_wdata", bus.wb_wdata_o[0], 32'h1101);
    repeat (4) next();

    // Flush together with stall: D$ cleared, MM/WB hold.
    for (int k = 0; k < 5; k++) begin
      next(); idle_ex(); issue(0, 1'b0, reg_addr_t'(16 + k), 32'(32'h1600 + k));
      if (k < 2) expect_wb(0, reg_addr_t'(16 + k), 32'(32'h1600 + k));
      if (k == 4) begin bus.flush_i = 1'b1; bus.stall_i = 1'b1; end
      #1;
      if (k == 4) begin
        chk("t6_pre_wb", bus.wb_waddr_o[0], 16);
        chk("t6_pre_mm", bus.mm_waddr_o[0], 17);
      end
    end
    next(); idle_ex(); bus.flush_i = 1'b0; bus.stall_i = 1'b0; #1;
    chk("t6_dc0", bus.dcache_waddr_o[0][0], 0);
    chk("t6_dc1", bus.dcache_waddr_o[1][0], 0);
    chk("t6_mm_hold", bus.mm_waddr_o[0], 17);
    chk("t6_mm_hold_data", bus.mm_wdata_o[0], 32'h1601);
    chk("t6_wb_hold", bus.wb_waddr_o[0], 16);
    next(); #1;
    chk("t6_wb_adv", bus.wb_waddr_o[0], 17);
    chk("t6_mm_empty", bus.mm_waddr_o[0], 0);
    repeat (4) next();

    // r0 is never a hazard, then asynchronous reset mid-stream.
    next(); bus.rs1_i = '0; bus.rs2_i = '0; issue(1, 1'b1, 5'd0, 32'h0); #1;
    chk("t7_hz_r0_ex", bus.hazard_o, 0);
    next(); idle_ex(); issue(0, 1'b0, 5'd21, 32'h2121); #1;
    chk("t7_hz_r0_dc0", bus.hazard_o, 0);
    next(); idle_ex(); #1;
    chk("t7_dc0_waddr", bus.dcache_waddr_o[0][0], 21);
    chk("t7_hz_r0_dc1", bus.hazard_o, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    next(); next();
    rst_n = 1'b1;
    repeat (3) next();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL wb_pending actual=%0d writes outstanding required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
